stage1: RTL and testbench

//   Operand-fetch stage 1 of the processor pipeline: resolves the value vr_value from the

---
 rtl/stage1.sv | 123 ++++++++++++
 tb/tb_stage1.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stage1.sv
// -----------------------------------------------------------------------------
// stage1 -- operand-fetch stage 1 of the processor pipeline.
//
// Resolves the operand vr_value from the source field vr_source.
// The addressing mode mblock_s1 selects how it is resolved:
//   0 = RAM direct     : vr_value = RAM[vr_source]               (zero latency)
//   1 = RAM indirect   : ptr = RAM[vr_source][15:0], then
//                        vr_value = RAM[ptr]                     (one cycle)
//   2 = input device   : vr_value = DEV[vr_source]               (zero latency)
//   3 = constant       : vr_value = zero-extended vr_source      (zero latency)
//
// Ports
//   clk                    in   1   system clock, rising edge
//   reset                  in   1   asynchronous, active-high reset
//   mblock_s1              in   2   addressing mode
//   vr_source              in   8   address / constant operand
//   in_valid               in   1   request valid; qualifies vr_valid, starts mode 1
//   ram_value              in   32  RAM read data (combinational from ram_address)
//   input_devices_value    in   32  device read data (combinational from address)
//   ram_address            out  16  RAM read address (0 when RAM not selected)
//   input_devices_address  out  8   device address (0 unless IDLE mode 2)
//   vr_value               out  32  resolved operand (combinational)
//   vr_valid               out  1   vr_value is final this cycle
//   busy                   out  1   mode-1 dereference in progress
//   vr_value_q             out  32  last valid vr_value, registered
// -----------------------------------------------------------------------------
module stage1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mblock_s1,
  input  logic [7:0]  vr_source,
  input  logic        in_valid,
  input  logic [31:0] ram_value,
  input  logic [31:0] input_devices_value,
  output logic [15:0] ram_address,
  output logic [7:0]  input_devices_address,
  output logic [31:0] vr_value,
  output logic        vr_valid,
  output logic        busy,
  output logic [31:0] vr_value_q
);

  typedef enum logic {
    IDLE  = 1'b0,
    DEREF = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_RAM_DIRECT   = 2'd0,
    MODE_RAM_INDIRECT = 2'd1,
    MODE_DEVICE       = 2'd2,
    MODE_CONSTANT     = 2'd3
  } mode_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [31:0] vr_value_d;
  mode_t       mode;

  assign mode = mode_t'(mblock_s1);

  always_comb begin
    state_d               = state_q;
    ptr_d                 = ptr_q;
    ram_address           = '0;
    input_devices_address = '0;
    vr_value              = '0;
    vr_valid              = 1'b0;
    busy                  = 1'b0;

    unique case (state_q)
      DEREF: begin
        // Second half of an indirect fetch; request inputs are ignored here.
        ram_address = ptr_q;
        vr_value    = ram_value;
        vr_valid    = 1'b1;
        busy        = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        unique case (mode)
          MODE_RAM_DIRECT: begin
            ram_address = {8'h00, vr_source};
            vr_value    = ram_value;
            vr_valid    = in_valid;
          end
          MODE_RAM_INDIRECT: begin
            ram_address = {8'h00, vr_source};
            if (in_valid) begin
              // Only the low 16 bits form the pointer; upper bits are ignored.
              ptr_d   = ram_value[15:0];
              state_d = DEREF;
            end
          end
          MODE_DEVICE: begin
            input_devices_address = vr_source;
            vr_value              = input_devices_value;
            vr_valid              = in_valid;
          end
          default: begin
            vr_value = {24'h000000, vr_source};
            vr_valid = in_valid;
          end
        endcase
      end
    endcase

    vr_value_d = vr_valid ? vr_value : vr_value_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      vr_value_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vr_value_q <= vr_value_d;
    end
  end

endmodule

// File: tb/tb_stage1.sv
// -----------------------------------------------------------------------------
// tb_stage1 -- directed self-checking bench for stage1.
// A small RAM model answers the indirect-mode fetch; otherwise ram_value is
// driven directly from the stimulus.
// -----------------------------------------------------------------------------
module tb_stage1;

  logic        clk;
  logic        reset;
  logic [1:0]  mblock_s1;
  logic [7:0]  vr_source;
  logic        in_valid;
  logic [31:0] ram_value;
  logic [31:0] input_devices_value;
  logic [15:0] ram_address;
  logic [7:0]  input_devices_address;
  logic [31:0] vr_value;
  logic        vr_valid;
  logic        busy;
  logic [31:0] vr_value_q;

  logic        use_mem;
  logic [31:0] ram_drv;

  int unsigned checks;
  int unsigned failures;

  stage1 dut (
    .clk                   (clk),
    .reset                 (reset),
    .mblock_s1             (mblock_s1),
    .vr_source             (vr_source),
    .in_valid              (in_valid),
    .ram_value             (ram_value),
    .input_devices_value   (input_devices_value),
    .ram_address           (ram_address),
    .input_devices_address (input_devices_address),
    .vr_value              (vr_value),
    .vr_valid              (vr_valid),
    .busy                  (busy),
    .vr_value_q            (vr_value_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: RAM[5]=0x00010200, RAM[0x0200]=77, everything else 0.
  always_comb begin
    if (use_mem) begin
      if (ram_address == 16'h0005)      ram_value = 32'h0001_0200;
      else if (ram_address == 16'h0200) ram_value = 32'd77;
      else                              ram_value = 32'h0;
    end else begin
      ram_value = ram_drv;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    mblock_s1 = 2'd0;
    vr_source = 8'd0;
    in_valid = 1'b0;
    use_mem = 1'b0;
    ram_drv = 32'd0;
    input_devices_value = 32'd0;

    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, vr_valid}, 32'd0);
    chk("rst_q", vr_value_q, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: RAM direct
    ram_drv = 32'd55; input_devices_value = 32'd22; vr_source = 8'd33; mblock_s1 = 2'd0;
    #1;
    chk("m0_value", vr_value, 32'd55);
    chk("m0_ram_addr", {16'd0, ram_address}, 32'd33);
    chk("m0_dev_addr", {24'd0, input_devices_address}, 32'd0);
    chk("m0_valid_off", {31'd0, vr_valid}, 32'd0);

    // 2: input device
    mblock_s1 = 2'd2;
    #1;
    chk("m2_value", vr_value, 32'd22);
    chk("m2_dev_addr", {24'd0, input_devices_address}, 32'd33);
    chk("m2_ram_addr", {16'd0, ram_address}, 32'd0);

    // 3: constant, including all-ones source
    mblock_s1 = 2'd3;
    #1;
    chk("m3_value", vr_value, 32'd33);
    chk("m3_ram_addr", {16'd0, ram_address}, 32'd0);
    vr_source = 8'hFF;
    in_valid = 1'b1;
    #1;
    chk("m3_ff", vr_value, 32'h0000_00FF);
    chk("m3_valid", {31'd0, vr_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("q_hold_invalid", vr_value_q, 32'd0);

    // 4: RAM indirect with pointer wrap (upper 16 bits of RAM[5] ignored)
    use_mem = 1'b1; mblock_s1 = 2'd1; vr_source = 8'd5; in_valid = 1'b1;
    #1;
    chk("m1_c0_addr", {16'd0, ram_address}, 32'd5);
    chk("m1_c0_valid", {31'd0, vr_valid}, 32'd0);
    chk("m1_c0_value", vr_value, 32'd0);
    chk("m1_c0_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    // Inputs change during DEREF and must be ignored.
    in_valid = 1'b0; mblock_s1 = 2'd3; vr_source = 8'd9;
    #1;
    chk("m1_c1_addr", {16'd0, ram_address}, 32'h0000_0200);
    chk("m1_c1_value", vr_value, 32'd77);
    chk("m1_c1_valid", {31'd0, vr_valid}, 32'd1);
    chk("m1_c1_busy", {31'd0, busy}, 32'd1);
    chk("m1_c1_dev_addr", {24'd0, input_devices_address}, 32'd0);
    @(posedge clk); #1;
    chk("m1_c2_busy", {31'd0, busy}, 32'd0);
    chk("m1_c2_q", vr_value_q, 32'd77);
    chk("m1_c2_value", vr_value, 32'd9);

    // 5: asynchronous reset during DEREF
    @(negedge clk);
    mblock_s1 = 2'd1; vr_source = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("m5_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("m5_busy", {31'd0, busy}, 32'd0);
    chk("m5_q", vr_value_q, 32'd0);
    chk("m5_valid", {31'd0, vr_valid}, 32'd0);
    chk("m5_ram_addr", {16'd0, ram_address}, 32'd5);
    @(negedge clk);
    reset = 1'b0;

    // 6: vr_value_q captures only while valid, then holds
    use_mem = 1'b0; mblock_s1 = 2'd0; vr_source = 8'd1; in_valid = 1'b1; ram_drv = 32'd1;
    @(posedge clk); #1;
    chk("m6_q1", vr_value_q, 32'd1);
    ram_drv = 32'd2;
    @(posedge clk); #1;
    chk("m6_q2", vr_value_q, 32'd2);
    ram_drv = 32'd3;
    @(posedge clk); #1;
    chk("m6_q3", vr_value_q, 32'd3);
    in_valid = 1'b0; ram_drv = 32'd9;
    #1;
    chk("m6_value", vr_value, 32'd9);
    chk("m6_valid", {31'd0, vr_valid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("m6_q_hold", vr_value_q, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
